// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch engine.
//
// Accepts a fetch request for PC_in, issues one registered read to
// instruction memory, and latches the returned word into IR_out together
// with the sequential next PC (PC4). Misaligned requests and memory
// timeouts are reported as one-cycle error pulses with the faulting
// address in BadVAddr. A flush aborts an outstanding fetch silently.
//
// Parameters
//   TIMEOUT   : wait cycles tolerated without mem_ack before bus_err
//   RESET_PC  : boot fetch address (mem_addr / PC4 reset basis)
//
// Ports
//   Clk          in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   fetch_start  in   request one fetch at PC_in
//   flush        in   abort an outstanding fetch; suppresses fetch_start
//   PC_in        in   fetch address
//   mem_req      out  registered read request
//   mem_addr     out  registered request address
//   mem_ack      in   memory returns data this cycle
//   mem_rdata    in   instruction word, valid with mem_ack
//   IR_out       out  latched instruction
//   PC4          out  fetched address + 4
//   fetch_done   out  pulse: IR_out/PC4 updated
//   addr_err     out  pulse: misaligned PC_in
//   bus_err      out  pulse: memory timeout
//   BadVAddr     out  faulting address for addr_err/bus_err
//   busy         out  fetch outstanding
module ifetch_unit #(
  parameter logic [7:0]  TIMEOUT  = 8'd255,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic [31:0] PC_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] IR_out,
  output logic [31:0] PC4,
  output logic        fetch_done,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] BadVAddr,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] ir_q;
  logic [31:0] pc4_q;
  logic        fetch_done_q;
  logic        addr_err_q;
  logic        bus_err_q;
  logic [31:0] badvaddr_q;
  logic [7:0]  cnt_q;

  // Sequential next PC; wraps naturally at 2^32.
  logic [31:0] pc4_d;
  assign pc4_d = mem_addr_q + 32'd4;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_PC;
      ir_q         <= '0;
      pc4_q        <= RESET_PC + 32'd4;
      fetch_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      badvaddr_q   <= '0;
      cnt_q        <= '0;
    end else begin
      // Status outputs are single-cycle pulses.
      fetch_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fetch_start && !flush) begin
            if (PC_in[1:0] != 2'b00) begin
              addr_err_q <= 1'b1;
              badvaddr_q <= PC_in;
            end else begin
              state_q    <= WAIT;
              mem_req_q  <= 1'b1;
              mem_addr_q <= PC_in;
              cnt_q      <= '0;
            end
          end
        end
        WAIT: begin
          // Priority: flush, then ack (beats timeout), then timeout.
          if (flush) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end else if (mem_ack) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            ir_q         <= mem_rdata;
            pc4_q        <= pc4_d;
            fetch_done_q <= 1'b1;
          end else if (cnt_q == TIMEOUT) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            bus_err_q  <= 1'b1;
            badvaddr_q <= mem_addr_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign IR_out     = ir_q;
  assign PC4        = pc4_q;
  assign fetch_done = fetch_done_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;
  assign BadVAddr   = badvaddr_q;
  assign busy       = (state_q == WAIT);

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: self-checking bench for ifetch_unit (TIMEOUT=4).
// Directed scenarios compare against constants; a randomized phase
// compares every cycle against a transaction-level reference model.
module tb_ifetch_unit;

  localparam logic [7:0]  TO  = 8'd4;
  localparam logic [31:0] RPC = 32'hBFC00000;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] PC_in = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] IR_out;
  logic [31:0] PC4;
  logic        fetch_done;
  logic        addr_err;
  logic        bus_err;
  logic [31:0] BadVAddr;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_unit #(.TIMEOUT(TO), .RESET_PC(RPC)) dut (
    .Clk(Clk), .reset(reset), .fetch_start(fetch_start), .flush(flush),
    .PC_in(PC_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .IR_out(IR_out), .PC4(PC4),
    .fetch_done(fetch_done), .addr_err(addr_err), .bus_err(bus_err),
    .BadVAddr(BadVAddr), .busy(busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog expired");
  end

  // Reference model: one outstanding transaction described by the
  // address it targets and how many cycles it has been waiting.
  bit          m_pending;
  int          m_waited;
  logic [31:0] m_addr, m_ir, m_pc4, m_bad;
  bit          m_done, m_aerr, m_berr;

  task automatic model_step();
    m_done = 0; m_aerr = 0; m_berr = 0;
    if (reset) begin
      m_pending = 0; m_waited = 0; m_addr = RPC; m_ir = 0;
      m_pc4 = RPC + 32'd4; m_bad = 0;
    end else if (!m_pending) begin
      if (fetch_start && !flush) begin
        if (PC_in % 4 != 0) begin
          m_aerr = 1; m_bad = PC_in;
        end else begin
          m_pending = 1; m_addr = PC_in; m_waited = 0;
        end
      end
    end else if (flush) begin
      m_pending = 0;
    end else if (mem_ack) begin
      m_pending = 0; m_ir = mem_rdata; m_pc4 = m_addr + 32'd4; m_done = 1;
    end else if (m_waited == int'(TO)) begin
      m_pending = 0; m_berr = 1; m_bad = m_addr;
    end else begin
      m_waited++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_start = 0; flush = 0; mem_ack = 0; reset = 0;
  endtask

  task automatic test_reset();
    // Reset with every other input active must still win.
    reset = 1; fetch_start = 1; flush = 1; mem_ack = 1; PC_in = 32'h1000;
    tick();
    idle_inputs();
    n_checks++;
    if ({busy, mem_req, fetch_done, addr_err, bus_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: actual %b required 00000", {busy, mem_req, fetch_done, addr_err, bus_err});
    end
    n_checks++;
    if (mem_addr !== 32'hBFC00000) begin
      n_fail++; $display("FAIL reset_mem_addr: actual %h required bfc00000", mem_addr);
    end
    n_checks++;
    if (IR_out !== 32'h0 || BadVAddr !== 32'h0) begin
      n_fail++; $display("FAIL reset_ir_bad: actual %h/%h required 0/0", IR_out, BadVAddr);
    end
    n_checks++;
    if (PC4 !== 32'hBFC00004) begin
      n_fail++; $display("FAIL reset_pc4: actual %h required bfc00004", PC4);
    end
  endtask

  task automatic test_basic_fetch();
    PC_in = 32'hBFC00000; fetch_start = 1;
    tick();
    fetch_start = 0;
    n_checks++;
    if (busy !== 1 || mem_req !== 1 || mem_addr !== 32'hBFC00000 || fetch_done !== 0) begin
      n_fail++; $display("FAIL basic_issue: actual busy=%b req=%b addr=%h done=%b required 1 1 bfc00000 0", busy, mem_req, mem_addr, fetch_done);
    end
    mem_ack = 1; mem_rdata = 32'h3C1D8000; PC_in = 32'h0;
    tick();
    mem_ack = 0;
    n_checks++;
    if (fetch_done !== 1 || IR_out !== 32'h3C1D8000 || PC4 !== 32'hBFC00004 || mem_req !== 0 || busy !== 0) begin
      n_fail++; $display("FAIL basic_complete: actual done=%b ir=%h pc4=%h req=%b busy=%b required 1 3c1d8000 bfc00004 0 0", fetch_done, IR_out, PC4, mem_req, busy);
    end
    mem_ack = 1; mem_rdata = 32'h12345678;  // ack while idle is ignored
    tick();
    mem_ack = 0;
    n_checks++;
    if (fetch_done !== 0 || IR_out !== 32'h3C1D8000) begin
      n_fail++; $display("FAIL basic_pulse_end: actual done=%b ir=%h required 0 3c1d8000", fetch_done, IR_out);
    end
  endtask

  task automatic test_addr_err();
    PC_in = 32'h80000182; fetch_start = 1;
    tick();
    fetch_start = 0;
    n_checks++;
    if (addr_err !== 1 || BadVAddr !== 32'h80000182 || mem_req !== 0 || busy !== 0 || fetch_done !== 0) begin
      n_fail++; $display("FAIL addr_err_pulse: actual aerr=%b bad=%h req=%b busy=%b done=%b required 1 80000182 0 0 0", addr_err, BadVAddr, mem_req, busy, fetch_done);
    end
    tick();
    n_checks++;
    if (addr_err !== 0 || mem_req !== 0) begin
      n_fail++; $display("FAIL addr_err_once: actual aerr=%b req=%b required 0 0", addr_err, mem_req);
    end
  endtask

  task automatic test_timeout();
    int unsigned hi_cycles = 0;
    PC_in = 32'h80000200; fetch_start = 1;
    tick();
    fetch_start = 0;
    while (mem_req === 1 && hi_cycles < 20) begin
      hi_cycles++;
      n_checks++;
      if (mem_addr !== 32'h80000200 || bus_err !== 0) begin
        n_fail++; $display("FAIL timeout_stable: actual addr=%h berr=%b required 80000200 0", mem_addr, bus_err);
      end
      tick();
    end
    n_checks++;
    if (hi_cycles != 5) begin
      n_fail++; $display("FAIL timeout_req_cycles: actual %0d required 5", hi_cycles);
    end
    n_checks++;
    if (bus_err !== 1 || BadVAddr !== 32'h80000200 || busy !== 0 || fetch_done !== 0) begin
      n_fail++; $display("FAIL timeout_bus_err: actual berr=%b bad=%h busy=%b done=%b required 1 80000200 0 0", bus_err, BadVAddr, busy, fetch_done);
    end
    tick();
    n_checks++;
    if (bus_err !== 0) begin
      n_fail++; $display("FAIL timeout_once: actual %b required 0", bus_err);
    end
  endtask

  task automatic test_ack_at_timeout();
    // Ack arriving in the final allowed wait cycle completes normally.
    PC_in = 32'h80000300; fetch_start = 1;
    tick();
    fetch_start = 0;
    repeat (4) tick();
    mem_ack = 1; mem_rdata = 32'hA5A50001;
    tick();
    mem_ack = 0;
    n_checks++;
    if (fetch_done !== 1 || bus_err !== 0 || IR_out !== 32'hA5A50001 || PC4 !== 32'h80000304) begin
      n_fail++; $display("FAIL ack_at_timeout: actual done=%b berr=%b ir=%h pc4=%h required 1 0 a5a50001 80000304", fetch_done, bus_err, IR_out, PC4);
    end
    tick();
  endtask

  task automatic test_flush();
    PC_in = 32'h80000400; fetch_start = 1;
    tick();
    fetch_start = 0;
    flush = 1; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    flush = 0; mem_ack = 0;
    n_checks++;
    if (busy !== 0 || mem_req !== 0 || fetch_done !== 0 || bus_err !== 0 || addr_err !== 0) begin
      n_fail++; $display("FAIL flush_state: actual busy=%b req=%b done=%b berr=%b aerr=%b required 0 0 0 0 0", busy, mem_req, fetch_done, bus_err, addr_err);
    end
    n_checks++;
    if (IR_out !== 32'hA5A50001 || PC4 !== 32'h80000304) begin
      n_fail++; $display("FAIL flush_keep_ir: actual ir=%h pc4=%h required a5a50001 80000304", IR_out, PC4);
    end
    // Flush in idle suppresses a simultaneous fetch_start.
    flush = 1; fetch_start = 1; PC_in = 32'h80000500;
    tick();
    flush = 0; fetch_start = 0;
    n_checks++;
    if (busy !== 0 || mem_req !== 0) begin
      n_fail++; $display("FAIL flush_idle: actual busy=%b req=%b required 0 0", busy, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    PC_in = 32'h80000600; fetch_start = 1;
    tick();
    PC_in = 32'h80000700;  // ignored: fetch already outstanding
    mem_ack = 1; mem_rdata = 32'h11110000;
    tick();
    mem_ack = 0;
    n_checks++;
    if (fetch_done !== 1 || PC4 !== 32'h80000604) begin
      n_fail++; $display("FAIL b2b_first: actual done=%b pc4=%h required 1 80000604", fetch_done, PC4);
    end
    // Still asserting fetch_start during the fetch_done cycle: accepted.
    tick();
    fetch_start = 0;
    n_checks++;
    if (busy !== 1 || mem_req !== 1 || mem_addr !== 32'h80000700 || fetch_done !== 0) begin
      n_fail++; $display("FAIL b2b_second_issue: actual busy=%b req=%b addr=%h done=%b required 1 1 80000700 0", busy, mem_req, mem_addr, fetch_done);
    end
    mem_ack = 1; mem_rdata = 32'h22220000;
    tick();
    mem_ack = 0;
    n_checks++;
    if (fetch_done !== 1 || IR_out !== 32'h22220000) begin
      n_fail++; $display("FAIL b2b_second_done: actual done=%b ir=%h required 1 22220000", fetch_done, IR_out);
    end
    tick();
  endtask

  task automatic test_wrap_and_reset();
    PC_in = 32'hFFFFFFFC; fetch_start = 1;
    tick();
    fetch_start = 0; mem_ack = 1; mem_rdata = 32'h0000000C;
    tick();
    mem_ack = 0;
    n_checks++;
    if (fetch_done !== 1 || PC4 !== 32'h00000000) begin
      n_fail++; $display("FAIL wrap_pc4: actual done=%b pc4=%h required 1 00000000", fetch_done, PC4);
    end
    PC_in = 32'h80000800; fetch_start = 1;
    tick();
    fetch_start = 0;
    tick();
    reset = 1; mem_ack = 1; fetch_start = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({busy, mem_req, fetch_done, addr_err, bus_err} !== 5'b0 || mem_addr !== 32'hBFC00000 || IR_out !== 32'h0 || PC4 !== 32'hBFC00004 || BadVAddr !== 32'h0) begin
      n_fail++; $display("FAIL midwait_reset: actual flags=%b addr=%h ir=%h pc4=%h bad=%h required 00000 bfc00000 0 bfc00004 0", {busy, mem_req, fetch_done, addr_err, bus_err}, mem_addr, IR_out, PC4, BadVAddr);
    end
  endtask

  task automatic test_random();
    logic [132:0] act, exp;
    for (int unsigned i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      fetch_start = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      mem_ack     = ($urandom_range(0, 4) == 0);
      mem_rdata   = $urandom;
      PC_in       = $urandom;
      if ($urandom_range(0, 3) != 0) PC_in[1:0] = 2'b00;
      tick();
      act = {busy, mem_req, fetch_done, addr_err, bus_err, mem_addr, IR_out, PC4, BadVAddr};
      exp = {m_pending, m_pending, m_done, m_aerr, m_berr, m_addr, m_ir, m_pc4, m_bad};
      n_checks++;
      if (act !== exp) begin
        n_fail++; $display("FAIL random_cycle_%0d: actual %h required %h", i, act, exp);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_addr_err();
    test_timeout();
    test_ack_at_timeout();
    test_flush();
    test_back_to_back();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: TIMEOUT, default 8'd255, max wait cycles for mem_ack before bus error.
REQ-002 Parameter: RESET_PC, default 32'hBFC00000, boot fetch address.
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 reset  input  1  synchronous, active-high reset; sampled only on posedge Clk.
REQ-005 fetch_start  input  1  control FSM requests one instruction fetch at PC_in.
REQ-006 flush  input  1  abort any fetch in progress (exception/redirect).
REQ-007 PC_in  input  32  current PC from the PC register.
REQ-008 mem_req  output  1  registered read request to instruction memory.
REQ-009 mem_addr  output  32  registered word address of the request.
REQ-010 mem_ack  input  1  memory returns data this cycle.
REQ-011 mem_rdata  input  32  instruction word, valid when mem_ack=1.
REQ-012 IR_out  output  32  latched instruction register.
REQ-013 PC4  output  32  fetched address + 4, fed back as the sequential next PC.
REQ-014 fetch_done  output  1  one-cycle pulse: IR_out/PC4 updated.
REQ-015 addr_err  output  1  one-cycle pulse: misaligned PC_in.
REQ-016 bus_err  output  1  one-cycle pulse: memory timeout.
REQ-017 BadVAddr  output  32  faulting address for addr_err/bus_err.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have exactly two states: IDLE and WAIT; busy = (state==WAIT).
REQ-020 IDLE, fetch_start=1, PC_in[1:0]!=0: remain IDLE, next cycle addr_err=1, BadVAddr=PC_in, mem_req stays 0.
REQ-021 IDLE, fetch_start=1, PC_in[1:0]==0: next cycle state=WAIT, mem_req=1, mem_addr=PC_in, wait counter=0.
REQ-022 WAIT: mem_req and mem_addr SHALL remain stable until ack, flush, or timeout; counter increments by 1 per cycle without ack.
REQ-023 WAIT with mem_ack=1 and flush=0: at that edge IR_out=mem_rdata, PC4=mem_addr+32'd4 (mod 2^32; 32'hFFFFFFFC yields 0), mem_req=0, state=IDLE, fetch_done=1 for the following cycle only.
REQ-024 Minimum latency: fetch_start to fetch_done = 2 cycles when mem_ack arrives in the first WAIT cycle.
REQ-025 WAIT with flush=1: state=IDLE, mem_req=0, IR_out/PC4 unchanged, no fetch_done, no error pulses; flush SHALL win over a simultaneous mem_ack.
REQ-026 flush in IDLE SHALL have no effect and SHALL suppress a simultaneous fetch_start.
REQ-027 WAIT with counter==TIMEOUT and mem_ack=0: state=IDLE, mem_req=0, bus_err=1 next cycle, BadVAddr=mem_addr; mem_ack in that same cycle SHALL win (normal completion).
REQ-028 fetch_start while in WAIT SHALL be ignored (no queuing).
REQ-029 fetch_start in the cycle fetch_done is high SHALL be accepted (back-to-back fetches, one idle cycle between requests minimum).
REQ-030 mem_ack while in IDLE SHALL be ignored.
REQ-031 fetch_done, addr_err, bus_err SHALL be mutually exclusive and never high two consecutive cycles from one request.

Reset
REQ-032 reset=1 at posedge Clk SHALL force, from any state including mid-WAIT: state=IDLE, mem_req=0, mem_addr=RESET_PC, IR_out=0, PC4=RESET_PC+4 (32'hBFC00004), fetch_done=0, addr_err=0, bus_err=0, BadVAddr=0, counter=0.
REQ-033 reset SHALL take priority over fetch_start, flush and mem_ack in the same cycle.

Verification
REQ-034 PC_in=32'hBFC00000, fetch_start 1 cycle, mem_ack+rdata=32'h3C1D8000 on first WAIT cycle -> fetch_done pulses cycle 2, IR_out=32'h3C1D8000, PC4=32'hBFC00004.
REQ-035 PC_in=32'h80000182, fetch_start -> addr_err 1 cycle, BadVAddr=32'h80000182, mem_req never asserts.
REQ-036 TIMEOUT=4, fetch from 32'h80000200, no ack -> mem_req high 5 WAIT cycles, then bus_err 1 cycle, BadVAddr=32'h80000200, busy=0.
REQ-037 Fetch pending, flush and mem_ack same cycle -> IDLE, IR_out/PC4 unchanged, no fetch_done.
REQ-038 Fetch from 32'hFFFFFFFC acked -> PC4=32'h00000000; then reset asserted mid-WAIT of a new fetch -> all outputs at REQ-032 values next cycle.
